bypass_fifo: RTL and testbench

- Parametrised successor to the single-cycle bypass wire primitive in the Bluespec Verilog primitives library.
- Adds `depth` entries of buffering. When the FIFO is empty, a same-cycle enqueue is visible combinationally on the dequeue side (zero-latency bypass); otherwise it behaves as a registered FIFO.
- Used wherever the generated RTL needs bypass-FIFO semantics (enq scheduled before first/deq) with bounded storage.

---
 rtl/bypass_fifo_pkg.sv | 28 ++
 rtl/bypass_fifo_mem.sv | 23 ++
 rtl/bypass_fifo.sv | 111 +++++++++++
 tb/tb_bypass_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bypass_fifo_pkg.sv
// Shared helpers for the bypass FIFO: constant log2, wrapping pointer increment
// and the per-edge operation encoding.
package bypass_fifo_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLR,
    OP_BYPASS,
    OP_PUSH,
    OP_POP,
    OP_PUSHPOP
  } fifo_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Explicit wrap so non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned p, input int unsigned n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/bypass_fifo_mem.sv
// Storage array for the bypass FIFO: one synchronous write port, one async read port.
module bypass_fifo_mem #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 2,
  parameter int unsigned aw    = 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [aw-1:0]    waddr_i,
  input  logic [width-1:0] wdata_i,
  input  logic [aw-1:0]    raddr_i,
  output logic [width-1:0] rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bypass_fifo.sv
// Bounded FIFO whose empty state passes an enqueue straight through to the
// dequeue side in the same cycle; otherwise a plain registered FIFO.
module bypass_fifo
  import bypass_fifo_pkg::*;
#(
  parameter int unsigned width   = 1,
  parameter int unsigned depth   = 2,
  parameter int unsigned guarded = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [width-1:0]          D_IN,
  input  logic                      ENQ,
  output logic                      FULL_N,
  output logic [width-1:0]          D_OUT,
  input  logic                      DEQ,
  output logic                      EMPTY_N,
  input  logic                      CLR,
  output logic [clog2(depth+1)-1:0] COUNT,
  output logic                      ERR
);

  localparam int unsigned CW = clog2(depth + 1);
  localparam int unsigned PW = (depth > 1) ? clog2(depth) : 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             stored, full, enq_bad, deq_bad, mem_we;
  logic [width-1:0] mem_rdata;
  fifo_op_e         op;

  // A single-entry FIFO may swap its only item even though FULL_N is low.
  always_comb begin
    stored  = (count_q != '0);
    full    = (count_q == CW'(depth));
    enq_bad = ENQ & full & ~((depth == 1) & DEQ);
    deq_bad = DEQ & ~stored & ~ENQ;

    op = OP_IDLE;
    if (CLR)                               op = OP_CLR;
    else if (!stored && ENQ && DEQ)        op = OP_BYPASS;
    else if (ENQ && !enq_bad && DEQ && stored) op = OP_PUSHPOP;
    else if (ENQ && !enq_bad)              op = OP_PUSH;
    else if (DEQ && stored)                op = OP_POP;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q | ((guarded != 0) & (enq_bad | deq_bad));
    case (op)
      OP_CLR: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        err_d    = 1'b0;
      end
      OP_PUSH: begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), depth));
        count_d  = count_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), depth));
        count_d  = count_q - CW'(1);
      end
      OP_PUSHPOP: begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), depth));
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), depth));
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign mem_we = (op == OP_PUSH) || (op == OP_PUSHPOP);

  bypass_fifo_mem #(
    .width(width),
    .depth(depth),
    .aw   (PW)
  ) u_mem (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(D_IN),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  assign D_OUT   = stored ? mem_rdata : D_IN;
  assign EMPTY_N = stored | ENQ;
  assign FULL_N  = ~full;
  assign COUNT   = count_q;
  assign ERR     = (guarded != 0) & err_q;

endmodule

// File: tb/tb_bypass_fifo.sv
// Scoreboard bench for bypass_fifo: depth-2 and depth-3 instances, 8-bit data.
module tb_bypass_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic [7:0] a_din = '0, a_dout;
  logic       a_enq = 1'b0, a_deq = 1'b0, a_clr = 1'b0;
  logic       a_full_n, a_empty_n, a_err;
  logic [1:0] a_count;

  logic [7:0] b_din = '0, b_dout;
  logic       b_enq = 1'b0, b_deq = 1'b0, b_clr = 1'b0;
  logic       b_full_n, b_empty_n, b_err;
  logic [1:0] b_count;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bypass_fifo #(.width(8), .depth(2), .guarded(1)) dut_a (
    .CLK(CLK), .RST(RST), .D_IN(a_din), .ENQ(a_enq), .FULL_N(a_full_n),
    .D_OUT(a_dout), .DEQ(a_deq), .EMPTY_N(a_empty_n), .CLR(a_clr),
    .COUNT(a_count), .ERR(a_err)
  );

  bypass_fifo #(.width(8), .depth(3), .guarded(1)) dut_b (
    .CLK(CLK), .RST(RST), .D_IN(b_din), .ENQ(b_enq), .FULL_N(b_full_n),
    .D_OUT(b_dout), .DEQ(b_deq), .EMPTY_N(b_empty_n), .CLR(b_clr),
    .COUNT(b_count), .ERR(b_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitors: every accepted dequeue must present the oldest expected item.
  always @(negedge CLK) begin
    if (!RST && !a_clr && a_deq && a_empty_n) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_dout: got %0h, required no item", a_dout);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        if (a_dout !== e) begin
          errors++;
          $display("FAIL a_dout: got %0h, required %0h", a_dout, e);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && !b_clr && b_deq && b_empty_n) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_dout: got %0h, required no item", b_dout);
      end else begin
        logic [7:0] e;
        e = qb.pop_front();
        if (b_dout !== e) begin
          errors++;
          $display("FAIL b_dout: got %0h, required %0h", b_dout, e);
        end
      end
    end
  end

  task automatic a_cyc(input logic enq, input logic deq, input logic clr,
                       input logic [7:0] d, input bit push);
    @(posedge CLK);
    #1;
    a_enq = enq; a_deq = deq; a_clr = clr; a_din = d;
    if (push) qa.push_back(d);
    if (clr) qa.delete();
    @(negedge CLK);
  endtask

  task automatic b_cyc(input logic enq, input logic deq, input logic [7:0] d, input bit push);
    @(posedge CLK);
    #1;
    b_enq = enq; b_deq = deq; b_din = d;
    if (push) qb.push_back(d);
    @(negedge CLK);
  endtask

  initial begin
    // Reset state
    @(negedge CLK);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_full_n", 32'(a_full_n), 1);
    chk("rst_empty_n", 32'(a_empty_n), 0);
    chk("rst_err", 32'(a_err), 0);
    RST = 1'b0;

    // Same-cycle bypass while empty
    a_cyc(1, 1, 0, 8'hA5, 1);
    chk("byp_empty_n", 32'(a_empty_n), 1);
    chk("byp_dout", 32'(a_dout), 32'hA5);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("byp_count", 32'(a_count), 0);
    chk("byp_empty_after", 32'(a_empty_n), 0);

    // Fill to depth then drain in order
    a_cyc(1, 0, 0, 8'h01, 1);
    a_cyc(1, 0, 0, 8'h02, 1);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("fill_count", 32'(a_count), 2);
    chk("fill_full_n", 32'(a_full_n), 0);
    chk("fill_head", 32'(a_dout), 32'h01);
    a_cyc(0, 1, 0, 8'h00, 0);
    a_cyc(0, 1, 0, 8'h00, 0);
    chk("drain1_count", 32'(a_count), 1);
    chk("drain1_full_n", 32'(a_full_n), 1);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("drain_count", 32'(a_count), 0);

    // Overflow: dropped enqueue, sticky error, cleared by CLR
    a_cyc(1, 0, 0, 8'h11, 1);
    a_cyc(1, 0, 0, 8'h22, 1);
    a_cyc(1, 0, 0, 8'h33, 0);
    chk("ovf_count", 32'(a_count), 2);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("ovf_count2", 32'(a_count), 2);
    chk("ovf_err", 32'(a_err), 1);
    a_cyc(0, 1, 0, 8'h00, 0);
    chk("ovf_err_sticky", 32'(a_err), 1);
    a_cyc(0, 0, 1, 8'h00, 0);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("clr_count", 32'(a_count), 0);
    chk("clr_err", 32'(a_err), 0);

    // Underflow: no state change, error set
    a_cyc(0, 1, 0, 8'h00, 0);
    chk("udf_empty_n", 32'(a_empty_n), 0);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("udf_count", 32'(a_count), 0);
    chk("udf_err", 32'(a_err), 1);
    a_cyc(0, 0, 1, 8'h00, 0);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("udf_clr_err", 32'(a_err), 0);

    // Depth-3 streaming across pointer wrap at COUNT=1
    b_cyc(1, 0, 8'h10, 1);
    for (int i = 0; i < 10; i++) begin
      b_cyc(1, 1, 8'(8'h11 + i), 1);
      chk("b_stream_count", 32'(b_count), 1);
    end
    b_cyc(0, 1, 8'h00, 0);
    b_cyc(0, 0, 8'h00, 0);
    chk("b_end_count", 32'(b_count), 0);
    chk("b_err", 32'(b_err), 0);

    // Asynchronous reset mid-cycle with two stored items
    a_cyc(1, 0, 0, 8'h44, 1);
    a_cyc(1, 0, 0, 8'h55, 1);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("pre_rst_count", 32'(a_count), 2);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_count", 32'(a_count), 0);
    chk("arst_full_n", 32'(a_full_n), 1);
    chk("arst_empty_n", 32'(a_empty_n), 0);
    qa.delete();
    qb.delete();
    RST = 1'b0;
    @(negedge CLK);
    a_cyc(1, 1, 0, 8'h66, 1);
    chk("post_rst_dout", 32'(a_dout), 32'h66);
    a_cyc(0, 0, 0, 8'h00, 0);
    chk("post_rst_count", 32'(a_count), 0);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
